// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl -- byte-level I2C master sequencer.
// Takes START / WRITE / READ / STOP commands over a valid/ready handshake and
// generates open-drain SCL/SDA drive enables at a quarter-SCL-period rate.
//
// Ports:
//   CLK, rst                   system clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/cmd_data/cmd_nack   command fields, latched at acceptance
//   rsp_valid/rsp_data/rsp_nack  one-cycle response at end of WRITE/READ
//   busy                       state is not IDLE
//   scl_in, sda_in             synchronized pad inputs
//   scl_oe, sda_oe             1 = pull line low, 0 = release
//
// state  | meaning
// IDLE   | waiting for a command, counters cleared, lines hold last level
// START  | 4 phases: release, SDA low, hold, SCL low
// WRITE  | 9 bits x 4 phases, 8 data bits MSB first then slave ACK slot
// READ   | 9 bits x 4 phases, 8 sampled bits then master ACK/NACK slot
// STOP   | 4 phases: both low, SCL release, SDA release, hold
module i2c_byte_ctrl #(
  parameter int QTR_DIV = 125,
  parameter int CNT_W   = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_STOP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QTR_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(QTR_DIV / 2 - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       ph_q;
  logic [3:0]       bit_q;
  logic [7:0]       data_q;
  logic [7:0]       rx_q;
  logic             nack_q;
  logic             ack_q;
  logic             scl_oe_q;
  logic             sda_oe_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_nack_q;

  logic       byte_op;
  logic       stretch;
  logic       tick;
  logic [3:0] bit_d;
  logic [2:0] bit_idx;
  logic       sda_bit_d;

  assign byte_op = (state_q == ST_WRITE) || (state_q == ST_READ);
  // Slave holding SCL low while we release it freezes the phase timer.
  assign stretch = !scl_in && ((byte_op && ph_q == 2'd2) || (state_q == ST_STOP && ph_q == 2'd1));
  assign tick    = (state_q != ST_IDLE) && !stretch && (cnt_q == CNT_MAX);
  assign bit_d   = bit_q + 4'd1;
  assign bit_idx = ~bit_d[2:0];

  // SDA drive level for the Q0 phase of the upcoming bit.
  always_comb begin
    sda_bit_d = 1'b0;
    if (bit_d == 4'd8) begin
      sda_bit_d = (state_q == ST_READ) ? !nack_q : 1'b0;
    end else if (state_q == ST_WRITE) begin
      sda_bit_d = !data_q[bit_idx];
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ph_q        <= 2'd0;
      bit_q       <= 4'd0;
      data_q      <= 8'h00;
      rx_q        <= 8'h00;
      nack_q      <= 1'b0;
      ack_q       <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
        ph_q  <= 2'd0;
        bit_q <= 4'd0;
        if (cmd_valid) begin
          data_q <= cmd_data;
          nack_q <= cmd_nack;
          case (cmd_op)
            2'd0: begin
              // SCL is left alone here; if it is held low it is released mid-P0.
              state_q  <= ST_START;
              sda_oe_q <= 1'b0;
            end
            2'd1: begin
              state_q  <= ST_WRITE;
              scl_oe_q <= 1'b1;
              sda_oe_q <= !cmd_data[7];
            end
            2'd2: begin
              state_q  <= ST_READ;
              scl_oe_q <= 1'b1;
              sda_oe_q <= 1'b0;
            end
            default: begin
              state_q  <= ST_STOP;
              scl_oe_q <= 1'b1;
              sda_oe_q <= 1'b1;
            end
          endcase
        end
      end else begin
        if (!stretch) cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) ph_q <= ph_q + 2'd1;
        case (state_q)
          ST_START: begin
            if (ph_q == 2'd0 && cnt_q == CNT_HALF) scl_oe_q <= 1'b0;
            if (tick) begin
              case (ph_q)
                2'd0:    sda_oe_q <= 1'b1;
                2'd2:    scl_oe_q <= 1'b1;
                2'd3:    state_q  <= ST_IDLE;
                default: ;
              endcase
            end
          end
          ST_STOP: begin
            if (tick) begin
              case (ph_q)
                2'd0:    scl_oe_q <= 1'b0;
                2'd1:    sda_oe_q <= 1'b0;
                2'd3:    state_q  <= ST_IDLE;
                default: ;
              endcase
            end
          end
          ST_WRITE, ST_READ: begin
            if (tick) begin
              case (ph_q)
                2'd0: scl_oe_q <= 1'b0;
                2'd2: begin
                  scl_oe_q <= 1'b1;
                  if (bit_q == 4'd8) ack_q <= sda_in;
                  else               rx_q  <= {rx_q[6:0], sda_in};
                end
                2'd3: begin
                  if (bit_q == 4'd8) begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= (state_q == ST_WRITE) ? data_q : rx_q;
                    rsp_nack_q  <= (state_q == ST_WRITE) ? ack_q : nack_q;
                  end else begin
                    bit_q    <= bit_d;
                    sda_oe_q <= sda_bit_d;
                  end
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Testbench for i2c_byte_ctrl: a per-command timeline model (list of bus
// phases with their durations) drives the slave side and supplies the
// expected outputs for every cycle.
module tb_i2c_byte_ctrl;
  localparam int Q = 125;

  logic       CLK = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;

  logic slave_sda;
  logic stretch_drv;

  // Wired-AND bus: line is low if master or slave pulls it.
  assign scl_in = !scl_oe && !stretch_drv;
  assign sda_in = !sda_oe && slave_sda;

  always #5 CLK = ~CLK;

  i2c_byte_ctrl #(.QTR_DIV(Q), .CNT_W(8)) dut (
    .CLK(CLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .busy(busy), .scl_in(scl_in), .sda_in(sda_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      if (failures >= 50) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  typedef struct packed {
    logic scl;
    logic sda;
    logic ssda;
    logic str;
  } ent_t;

  ent_t tl[$];
  logic cur_scl;
  logic exp_busy, exp_scl, exp_sda, exp_rspv, exp_rnack;
  logic [7:0] exp_rdata;
  bit   chk_en;

  int         early_n;
  logic [1:0] nxt_op;
  logic [7:0] nxt_data;
  logic       nxt_nack;

  task automatic add_ph(input logic scl, input logic sda, input logic ssda, input int len, input int slen);
    ent_t e;
    for (int i = 0; i < len; i++) begin
      e.scl = scl; e.sda = sda; e.ssda = ssda; e.str = (i < slen);
      tl.push_back(e);
    end
  endtask

  // Expected bus timeline for one command, one entry per clock after acceptance.
  task automatic build(input logic [1:0] op, input logic [7:0] data, input logic nack,
                       input logic [7:0] sbyte, input logic sack, input int sbit, input int slen);
    tl.delete();
    case (op)
      2'd0: begin
        add_ph(cur_scl, 1'b0, 1'b1, Q / 2, 0);
        add_ph(1'b0, 1'b0, 1'b1, Q - Q / 2, 0);
        add_ph(1'b0, 1'b1, 1'b1, Q, 0);
        add_ph(1'b0, 1'b1, 1'b1, Q, 0);
        add_ph(1'b1, 1'b1, 1'b1, Q, 0);
      end
      2'd3: begin
        add_ph(1'b1, 1'b1, 1'b1, Q, 0);
        add_ph(1'b0, 1'b1, 1'b1, Q + slen, slen);
        add_ph(1'b0, 1'b0, 1'b1, Q, 0);
        add_ph(1'b0, 1'b0, 1'b1, Q, 0);
      end
      default: begin
        for (int b = 0; b < 9; b++) begin
          logic v, s;
          int sl;
          sl = (b == sbit) ? slen : 0;
          if (op == 2'd1) begin
            v = (b < 8) ? !data[7-b] : 1'b0;
            s = (b < 8) ? 1'b1 : sack;
          end else begin
            v = (b < 8) ? 1'b0 : !nack;
            s = (b < 8) ? sbyte[7-b] : 1'b1;
          end
          add_ph(1'b1, v, s, Q, 0);
          add_ph(1'b0, v, s, Q, 0);
          add_ph(1'b0, v, s, Q + sl, sl);
          add_ph(1'b1, v, s, Q, 0);
        end
      end
    endcase
  endtask

  task automatic play(input int from, input int to);
    for (int i = from; i < to; i++) begin
      exp_busy = 1'b1; exp_rspv = 1'b0;
      exp_scl = tl[i].scl; exp_sda = tl[i].sda;
      slave_sda = tl[i].ssda; stretch_drv = tl[i].str;
      if (early_n > 0 && i == tl.size() - early_n) begin
        cmd_valid = 1'b1; cmd_op = nxt_op; cmd_data = nxt_data; cmd_nack = nxt_nack;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      exp_rspv = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic nack,
                         input logic [7:0] sbyte, input logic sack, input int sbit, input int slen);
    if (!cmd_valid) begin
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_nack = nack;
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_data = 8'($urandom); cmd_nack = 1'($urandom);
    build(op, data, nack, sbyte, sack, sbit, slen);
    play(0, tl.size());
    exp_busy = 1'b0;
    exp_scl = tl[tl.size()-1].scl;
    exp_sda = tl[tl.size()-1].sda;
    cur_scl = exp_scl;
    slave_sda = 1'b1; stretch_drv = 1'b0;
    if (op == 2'd1) begin
      exp_rspv = 1'b1; exp_rdata = data; exp_rnack = sack;
    end else if (op == 2'd2) begin
      exp_rspv = 1'b1; exp_rdata = sbyte; exp_rnack = nack;
    end else begin
      exp_rspv = 1'b0;
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("scl_oe", scl_oe, exp_scl);
      chk("sda_oe", sda_oe, exp_sda);
      chk("busy", busy, exp_busy);
      chk("cmd_ready", cmd_ready, !exp_busy);
      chk("rsp_valid", rsp_valid, exp_rspv);
      chk("rsp_data", rsp_data, exp_rdata);
      chk("rsp_nack", rsp_nack, exp_rnack);
    end
  end

  // Observed SDA level at each SCL high pulse of a transfer.
  logic        prev_scl_m = 1'b0;
  int          obs_cnt = 0;
  logic [15:0] obs_bits = 16'h0;
  always @(negedge CLK) begin
    if (prev_scl_m && !scl_oe && busy) begin
      obs_cnt++;
      obs_bits = {obs_bits[14:0], !sda_oe};
    end
    prev_scl_m = scl_oe;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       nack;
    logic [7:0] sbyte;
    logic       sack;
    int         sbit;
    int         slen;
  } rc_t;
  rc_t rc[10];

  initial begin
    int c0, cnt, first;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00; cmd_nack = 1'b0;
    slave_sda = 1'b1; stretch_drv = 1'b0; chk_en = 1'b0; early_n = 0;
    nxt_op = 2'd0; nxt_data = 8'h00; nxt_nack = 1'b0;
    cur_scl = 1'b0; exp_busy = 1'b0; exp_scl = 1'b0; exp_sda = 1'b0;
    exp_rspv = 1'b0; exp_rdata = 8'h00; exp_rnack = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_data, 8'h00);
    #2 rst = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1'b1;
    idle(1000);

    // START from an idle bus
    run_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 9, 0);
    chk("start_len", tl.size(), 500);
    first = -1;
    for (int i = tl.size() - 1; i >= 0; i--) if (tl[i].sda) first = i;
    chk("start_sda_at", first, 125);
    first = -1;
    for (int i = tl.size() - 1; i >= 0; i--) if (tl[i].scl) first = i;
    chk("start_scl_at", first, 375);
    idle(5);

    // WRITE 0xA5, slave ACKs
    c0 = obs_cnt;
    run_cmd(2'd1, 8'hA5, 1'b0, 8'h00, 1'b0, 9, 0);
    chk("wr_len", tl.size(), 4500);
    chk("wr_pulses", obs_cnt - c0, 9);
    chk("wr_bits", obs_bits[8:0], {8'hA5, 1'b1});
    chk("wr_rspv", rsp_valid, 1);
    chk("wr_rdata", rsp_data, 8'hA5);
    chk("wr_ack", rsp_nack, 0);
    idle(3);

    // WRITE 0xA5, slave NACKs
    run_cmd(2'd1, 8'hA5, 1'b0, 8'h00, 1'b1, 9, 0);
    chk("wr_nack", rsp_nack, 1);
    idle(2);

    // READ 0x3C with master NACK
    run_cmd(2'd2, 8'h00, 1'b1, 8'h3C, 1'b0, 9, 0);
    chk("rd_rdata", rsp_data, 8'h3C);
    chk("rd_nack_echo", rsp_nack, 1);
    cnt = 0;
    for (int i = 32 * Q; i < 36 * Q; i++) if (!tl[i].sda) cnt++;
    chk("rd_nack_slot", cnt, 500);
    idle(1);

    // READ 0x3C with master ACK
    run_cmd(2'd2, 8'h00, 1'b0, 8'h3C, 1'b0, 9, 0);
    chk("rd_ack_rdata", rsp_data, 8'h3C);
    cnt = 0;
    for (int i = 32 * Q; i < 36 * Q; i++) if (tl[i].sda) cnt++;
    chk("rd_ack_slot", cnt, 500);

    // WRITE with a 300-cycle stretch at bit 3 Q2, presented back-to-back
    run_cmd(2'd1, 8'hA5, 1'b0, 8'h00, 1'b0, 3, 300);
    chk("str_len", tl.size(), 4800);
    chk("str_rdata", rsp_data, 8'hA5);
    idle(4);

    // STOP
    run_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 9, 0);
    chk("stop_len", tl.size(), 500);
    idle(10);

    // Reset during bit 5 of a READ
    run_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 9, 0);
    idle(2);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 8'h00; cmd_nack = 1'b0;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    build(2'd2, 8'h00, 1'b0, 8'hC3, 1'b0, 9, 0);
    play(0, 2510);
    chk("pre_rst_scl", scl_oe, 1);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_scl", scl_oe, 0);
    chk("async_sda", sda_oe, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("rst_hold_rspv", rsp_valid, 0);
    end
    #2 rst = 1'b1;
    @(posedge CLK); #1;
    exp_busy = 1'b0; exp_scl = 1'b0; exp_sda = 1'b0; cur_scl = 1'b0;
    exp_rspv = 1'b0; exp_rdata = 8'h00; exp_rnack = 1'b0;
    slave_sda = 1'b1; stretch_drv = 1'b0;
    chk_en = 1'b1;
    idle(2100);

    // Randomized command stream, some commands offered while still busy
    for (int c = 0; c < 10; c++) begin
      rc[c].op    = 2'($urandom_range(0, 3));
      rc[c].data  = 8'($urandom);
      rc[c].nack  = 1'($urandom);
      rc[c].sbyte = 8'($urandom);
      rc[c].sack  = 1'($urandom);
      rc[c].sbit  = $urandom_range(0, 8);
      rc[c].slen  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 9 && $urandom_range(0, 2) == 0) begin
        early_n = $urandom_range(1, 20);
        nxt_op = rc[c+1].op; nxt_data = rc[c+1].data; nxt_nack = rc[c+1].nack;
      end else begin
        early_n = 0;
      end
      if (!cmd_valid) idle($urandom_range(0, 3));
      run_cmd(rc[c].op, rc[c].data, rc[c].nack, rc[c].sbyte, rc[c].sack, rc[c].sbit, rc[c].slen);
    end
    early_n = 0;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
